arb_pri_32x3: RTL and testbench
===============================

ARB_PRI_32X3 -- requirements
Module: arb_pri_32x3

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data width of every source and of the output.
REQ-002 The block SHALL have parameter STARVE_MAX, default 15, the wait-cycle count at which a lower-priority source is forced to win.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous and active-low.
REQ-005 Port src_valid  input  3  per-source request; bit i is for source i.
REQ-006 Ports src_data0, src_data1, src_data2  input  WIDTH  source payloads.
REQ-007 Port src_ready  output  3  per-source accept; at most one bit high per cycle.
REQ-008 Port out_valid  output  1  output register holds a payload.
REQ-009 Port out_data  output  WIDTH  registered payload.
REQ-010 Port out_src  output  3  one-hot tag of the source that produced out_data; a valid sel vector for the downstream priority select mux.
REQ-011 Port out_ready  input  1  downstream accept.

Function
REQ-012 A source transfer SHALL occur in a cycle where src_valid[i] and src_ready[i] are both 1; an output transfer SHALL occur where out_valid and out_ready are both 1.
REQ-013 Sources SHALL hold valid and data stable until accepted; the block is not required to tolerate withdrawal.
REQ-014 can_load SHALL equal (!out_valid | out_ready); src_ready SHALL be 0 whenever can_load is 0.
REQ-015 When can_load is 1, src_ready SHALL be the one-hot grant of the winning valid source, or 0 if no source is valid.
REQ-016 Default priority SHALL be fixed: source 0 first, then source 1, then source 2.
REQ-017 Each of sources 1 and 2 SHALL have a starvation counter.
REQ-018 A starvation counter SHALL increment, saturating at STARVE_MAX, in each cycle its source is valid and not granted.
REQ-019 A starvation counter SHALL clear in the cycle its source is granted, and SHALL hold while its source is not valid.
REQ-020 If a counter equals STARVE_MAX and its source is valid, that source SHALL override default priority; if both counters are saturated, source 1 wins.
REQ-021 On a source transfer, out_data and out_src SHALL load the granted payload and tag at the next edge, and out_valid SHALL be set (latency 1 cycle).
REQ-022 On an output transfer with no simultaneous source transfer, out_valid SHALL clear; out_data and out_src SHALL hold their values.
REQ-023 A simultaneous output transfer and source transfer SHALL replace the register contents with no bubble, giving throughput 1 transfer per cycle.
REQ-024 When out_valid is 1 and out_ready is 0, out_data and out_src SHALL be stable and no grant SHALL issue.
REQ-025 src_ready SHALL be a combinational function of src_valid, the starvation counters, out_valid and out_ready; there SHALL be no combinational path from src_data to src_ready.

Reset
REQ-026 While rst_n is 0 at a clock edge, the following SHALL be cleared to 0: out_valid, out_data, out_src and both starvation counters.
REQ-027 During reset, src_ready SHALL be 0.
REQ-028 A payload held in the output register when reset asserts SHALL be discarded.
REQ-029 The first grant after reset SHALL occur no earlier than the first edge at which rst_n is 1.

Structure
REQ-030 The source-index constants (SRC0..SRC2), the count NSRC=3 and the counter width (clog2(STARVE_MAX+1)) SHALL live in the shared a2p package.
REQ-031 The grant logic SHALL be one sub-module, arb_grant_3, that is purely combinational: its inputs are valid, starve_hit and enable, and its output is a one-hot grant.
REQ-032 The output payload mux SHALL reuse the existing 32x3 priority select, with the grant as sel.

Verification
REQ-033 The bench SHALL hold out_ready=1 and drive src_valid=3'b111 with data0=0xA0, data1=0xB1 and data2=0xC2 held for 20 cycles. The required response:
- source 0 is granted every cycle;
- source 1's counter saturates at cycle 15 and source 1 is then granted, with out_src=3'b010 and out_data=0xB1 one cycle later;
- source 2 is granted next, with out_src=3'b100.
REQ-034 The bench SHALL drive src_valid=3'b100 with data 0x1234 and out_ready=0. The required response is 0x1234 accepted once, then out_valid=1 with stable data and src_ready=0 for all stall cycles, then release with out_ready=1.
REQ-035 The bench SHALL drive back-to-back traffic on source 0 (data 1, 2, 3, 4) with out_ready=1. The required response is out_data 1, 2, 3, 4 on consecutive cycles with out_valid continuously 1.
REQ-036 The bench SHALL assert rst_n=0 for one cycle while out_valid=1 and source 2's counter is 7. The required response at the next edge is out_valid=0, out_data=0, out_src=0, counters=0 and src_ready=0 during the reset cycle.
REQ-037 The bench SHALL drive src_valid=0 for 10 cycles after reset. The required response is src_ready=0, out_valid=0 and counters held at 0.

Source files
------------

// File: rtl/a2p_pkg.sv
// Shared constants and helpers for the three-source priority arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package a2p_pkg;

    localparam int NSRC = 3;
    localparam int SRC0 = 0;
    localparam int SRC1 = 1;
    localparam int SRC2 = 2;

    // Default saturation value for the starvation counters.
    localparam int STARVE_MAX_DEF = 15;

    typedef logic [NSRC-1:0] src_vec_t;

    // Counter width needed to hold 0..smax inclusive.
    function automatic int cnt_width(input int smax);
        return (smax < 1) ? 1 : $clog2(smax + 1);
    endfunction

    // One-hot of the lowest set bit; lower index means higher priority.
    function automatic src_vec_t first_one(input src_vec_t v);
        return v & (~v + src_vec_t'(1));
    endfunction

endpackage

// File: rtl/arb_grant_3.sv
// Combinational one-hot grant for three sources with starvation override.
// Latency: 0 cycles (pure combinational).
// Backpressure: grant is forced to zero whenever enable is low.
module arb_grant_3
    import a2p_pkg::*;
(
    input  logic [NSRC-1:0] valid,
    input  logic [NSRC-1:0] starve_hit,
    input  logic            enable,
    output logic [NSRC-1:0] grant
);

    src_vec_t starved;

    // Saturated sources preempt fixed priority; among them the lowest index wins.
    always_comb begin
        grant   = '0;
        starved = valid & starve_hit;
        if (enable) begin
            if (|starved) begin
                grant = first_one(starved);
            end else begin
                grant = first_one(valid);
            end
        end
    end

endmodule

// File: rtl/prio_sel_32x3.sv
// Three-input priority select mux; bit 0 of sel has the highest priority.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs zero when sel is empty.
module prio_sel_32x3 #(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic [WIDTH-1:0] dout
);

    // Lowest selected input drives the output.
    always_comb begin
        dout = '0;
        if (sel[0]) begin
            dout = d0;
        end else if (sel[1]) begin
            dout = d1;
        end else if (sel[2]) begin
            dout = d2;
        end
    end

endmodule

// File: rtl/arb_pri_32x3.sv
// Fixed-priority 3:1 arbiter with starvation override into a single output register.
// Latency: 1 cycle from source transfer to out_valid; full throughput.
// Backpressure: no grant while the output register is full and out_ready is low.
module arb_pri_32x3
    import a2p_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       src_valid,
    input  logic [WIDTH-1:0] src_data0,
    input  logic [WIDTH-1:0] src_data1,
    input  logic [WIDTH-1:0] src_data2,
    output logic [2:0]       src_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       out_src,
    input  logic             out_ready
);

    localparam int CW = cnt_width(STARVE_MAX);
    localparam logic [CW-1:0] CNT_SAT = CW'(STARVE_MAX);

    logic [CW-1:0]    starve_cnt1;
    logic [CW-1:0]    starve_cnt2;
    logic             can_load;
    src_vec_t         starve_hit;
    logic [WIDTH-1:0] sel_data;

    // Register may accept a new payload when empty or draining this cycle.
    always_comb begin
        can_load          = !out_valid || out_ready;
        starve_hit        = '0;
        starve_hit[SRC0]  = 1'b0;
        starve_hit[SRC1]  = (starve_cnt1 == CNT_SAT);
        starve_hit[SRC2]  = (starve_cnt2 == CNT_SAT);
    end

    // Reset gates the enable so no grant can issue while rst_n is low.
    arb_grant_3 u_grant (
        .valid      (src_valid),
        .starve_hit (starve_hit),
        .enable     (can_load && rst_n),
        .grant      (src_ready)
    );

    prio_sel_32x3 #(
        .WIDTH (WIDTH)
    ) u_sel (
        .sel  (src_ready),
        .d0   (src_data0),
        .d1   (src_data1),
        .d2   (src_data2),
        .dout (sel_data)
    );

    // Output register: load on grant, otherwise empty on downstream accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (|src_ready) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_src   <= src_ready;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Starvation counters: clear on grant, count while waiting, hold when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt1 <= '0;
            starve_cnt2 <= '0;
        end else begin
            if (src_ready[SRC1]) begin
                starve_cnt1 <= '0;
            end else if (src_valid[SRC1] && (starve_cnt1 != CNT_SAT)) begin
                starve_cnt1 <= starve_cnt1 + 1'b1;
            end
            if (src_ready[SRC2]) begin
                starve_cnt2 <= '0;
            end else if (src_valid[SRC2] && (starve_cnt2 != CNT_SAT)) begin
                starve_cnt2 <= starve_cnt2 + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_arb_pri_32x3.sv
// Directed bench for arb_pri_32x3 with a scoreboard-driven output monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_arb_pri_32x3;

    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [2:0]       src;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [2:0]       src_valid;
    logic [WIDTH-1:0] src_data0;
    logic [WIDTH-1:0] src_data1;
    logic [WIDTH-1:0] src_data2;
    logic [2:0]       src_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       out_src;
    logic             out_ready;

    int   checks;
    int   failures;
    exp_t sb[$];
    exp_t mon_e;

    arb_pri_32x3 #(
        .WIDTH      (WIDTH),
        .STARVE_MAX (15)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_valid (src_valid),
        .src_data0 (src_data0),
        .src_data1 (src_data1),
        .src_data2 (src_data2),
        .src_ready (src_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input logic [2:0] s);
        exp_t e;
        e.data = d;
        e.src  = s;
        sb.push_back(e);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output transfer must match the oldest expected payload.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("out_data", 64'(out_data), 64'(mon_e.data));
                chk("out_src", 64'(out_src), 64'(mon_e.src));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]       eg;
        logic [WIDTH-1:0] ed;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        src_valid = '0;
        src_data0 = '0;
        src_data1 = '0;
        src_data2 = '0;
        out_ready = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_src_ready", 64'(src_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_src", 64'(out_src), 64'd0);
        next_cyc();
        rst_n = 1'b1;

        // Idle after reset: nothing granted, counters stay at zero.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_src_ready", 64'(src_ready), 64'd0);
            chk("idle_out_valid", 64'(out_valid), 64'd0);
            chk("idle_cnt1", 64'(dut.starve_cnt1), 64'd0);
            chk("idle_cnt2", 64'(dut.starve_cnt2), 64'd0);
            next_cyc();
        end

        // All three sources requesting: starvation forces src1 then src2.
        out_ready = 1'b1;
        src_valid = 3'b111;
        src_data0 = 32'hA0;
        src_data1 = 32'hB1;
        src_data2 = 32'hC2;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 15) begin
                eg = 3'b010;
                ed = 32'hB1;
                chk("cnt1_saturated", 64'(dut.starve_cnt1), 64'd15);
            end else if (c == 16) begin
                eg = 3'b100;
                ed = 32'hC2;
            end else begin
                eg = 3'b001;
                ed = 32'hA0;
            end
            chk("starve_grant", 64'(src_ready), 64'(eg));
            push(ed, eg);
            next_cyc();
        end
        src_valid = '0;
        repeat (3) next_cyc();

        // Stall: one accept, then no grant and stable output while blocked.
        out_ready = 1'b0;
        src_valid = 3'b100;
        src_data2 = 32'h1234;
        @(negedge clk);
        chk("stall_first_grant", 64'(src_ready), 64'b100);
        push(32'h1234, 3'b100);
        next_cyc();
        src_data2 = 32'h5678;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_src_ready", 64'(src_ready), 64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_out_data", 64'(out_data), 64'h1234);
            chk("stall_out_src", 64'(out_src), 64'b100);
            next_cyc();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_grant", 64'(src_ready), 64'b100);
        push(32'h5678, 3'b100);
        next_cyc();
        src_valid = '0;
        repeat (2) next_cyc();

        // Back-to-back on source 0 with no bubbles.
        for (int k = 1; k <= 4; k++) begin
            src_valid = 3'b001;
            src_data0 = WIDTH'(k);
            @(negedge clk);
            chk("b2b_grant", 64'(src_ready), 64'b001);
            if (k > 1) chk("b2b_out_valid", 64'(out_valid), 64'd1);
            push(WIDTH'(k), 3'b001);
            next_cyc();
        end
        src_valid = '0;
        @(negedge clk);
        chk("b2b_last_valid", 64'(out_valid), 64'd1);
        next_cyc();
        @(negedge clk);
        chk("b2b_drained", 64'(out_valid), 64'd0);
        next_cyc();

        // Reset with a full register and src2 counter at 7.
        rst_n = 1'b0;
        next_cyc();
        rst_n     = 1'b1;
        out_ready = 1'b0;
        src_valid = 3'b101;
        src_data0 = 32'hD0;
        src_data2 = 32'hC2;
        repeat (7) @(posedge clk);
        #1;
        @(negedge clk);
        chk("pre_rst_cnt2", 64'(dut.starve_cnt2), 64'd7);
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        rst_n     = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("in_rst_src_ready", 64'(src_ready), 64'd0);
        next_cyc();
        rst_n     = 1'b1;
        src_valid = '0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        chk("post_rst_out_data", 64'(out_data), 64'd0);
        chk("post_rst_out_src", 64'(out_src), 64'd0);
        chk("post_rst_cnt1", 64'(dut.starve_cnt1), 64'd0);
        chk("post_rst_cnt2", 64'(dut.starve_cnt2), 64'd0);
        next_cyc();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
